// File: rtl/program_counter_pkg.sv
// Shared program-counter constants for the IF stage, the IF/ID register and
// the branch unit. The address width follows the codebase-wide `PC_WIDTH
// macro, so every consumer agrees on the bus size.
//
// Contents:
//   DEF_PC_WIDTH  address bus width (from `PC_WIDTH, 32 when undefined)
//   DEF_PC_INCR   byte increment per sequential instruction
//   DEF_RESET_PC  fetch address loaded on reset
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package program_counter_pkg;
  localparam int unsigned DEF_PC_WIDTH = `PC_WIDTH;
  localparam int unsigned DEF_PC_INCR  = 4;
  localparam int unsigned DEF_RESET_PC = 0;
endpackage

// File: rtl/program_counter.sv
// Program counter for the IF stage of the 5-stage MIPS pipeline. Holds the
// current fetch address and presents it, qualified by a registered fetch-valid,
// to instruction memory. A redirect from later stages always wins, even while
// the fetch is stalled, so a branch/jump target is never dropped.
//
// Ports:
//   pc_clk          in   system clock, rising edge
//   pc_rst          in   synchronous active-high reset
//   pc_i_ce         in   fetch enable from pipeline control (0 = stall)
//   pc_i_change_pc  in   redirect request, loads pc_i_pc
//   pc_i_pc         in   redirect target address
//   pc_o_pc         out  current fetch address (registered)
//   pc_o_ce         out  fetch-valid to instruction memory (registered)
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   PC_INCR  = PC_WIDTH'(DEF_PC_INCR),
  parameter logic [PC_WIDTH-1:0]   RESET_PC = PC_WIDTH'(DEF_RESET_PC)
) (
  input  logic                pc_clk,
  input  logic                pc_rst,
  input  logic                pc_i_ce,
  input  logic                pc_i_change_pc,
  input  logic [PC_WIDTH-1:0] pc_i_pc,
  output logic [PC_WIDTH-1:0] pc_o_pc,
  output logic                pc_o_ce
);

  logic [PC_WIDTH-1:0] next_pc;

  // Unsigned modulo-2^PC_WIDTH step; the carry out is intentionally dropped.
  function automatic logic [PC_WIDTH-1:0] pc_step(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_INCR;
  endfunction

  // Advancing only when the current address was already presented valid
  // guarantees each address (including RESET_PC after reset, and the held
  // address after a stall) is fetched once before moving on.
  always_comb begin
    next_pc = pc_o_pc;
    if (pc_i_change_pc) begin
      next_pc = pc_i_pc;
    end else if (pc_i_ce && pc_o_ce) begin
      next_pc = pc_step(pc_o_pc);
    end
  end

  always_ff @(posedge pc_clk) begin
    if (pc_rst) begin
      pc_o_pc <= RESET_PC;
      pc_o_ce <= 1'b0;
    end else begin
      pc_o_pc <= next_pc;
      pc_o_ce <= pc_i_ce;
    end
  end

`ifndef SYNTHESIS
  a_ce_low_after_reset : assert property (@(posedge pc_clk) pc_rst |=> !pc_o_ce);

  a_no_advance_unless_valid : assert property (@(posedge pc_clk)
    (!pc_rst && !pc_i_change_pc && !pc_o_ce) |=> $stable(pc_o_pc));
`endif

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;
  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         ce_in;
  logic         change;
  logic [W-1:0] target;
  logic [W-1:0] pc_out;
  logic         ce_out;

  int total;
  int bad;

  program_counter dut (
    .pc_clk        (clk),
    .pc_rst        (rst),
    .pc_i_ce       (ce_in),
    .pc_i_change_pc(change),
    .pc_i_pc       (target),
    .pc_o_pc       (pc_out),
    .pc_o_ce       (ce_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_in = 1'b1; change = 1'b1; target = 32'h40;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (pc_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_pc cycle %0d: got %h expected %h", i, pc_out, 32'h0);
      end
      total++;
      if (ce_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_ce cycle %0d: got %b expected 0", i, ce_out);
      end
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0; ce_in = 1'b1; change = 1'b0; target = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (pc_out !== W'(4 * i)) begin
        bad++;
        $display("FAIL seq_pc step %0d: got %h expected %h", i, pc_out, W'(4 * i));
      end
      total++;
      if (ce_out !== 1'b1) begin
        bad++;
        $display("FAIL seq_ce step %0d: got %b expected 1", i, ce_out);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_pc [9];
    logic         exp_ce [9];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'h10};
    exp_ce = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; change = 1'b0; ce_in = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ce_in = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
      tick();
      total++;
      if (pc_out !== exp_pc[i] || ce_out !== exp_ce[i]) begin
        bad++;
        $display("FAIL stall step %0d: got pc=%h ce=%b expected pc=%h ce=%b",
                 i, pc_out, ce_out, exp_pc[i], exp_ce[i]);
      end
    end
  endtask

  task automatic test_redirect();
    logic         v_ce  [9];
    logic         v_chg [9];
    logic [W-1:0] v_tgt [9];
    logic [W-1:0] exp_pc[9];
    logic         exp_ce[9];
    // redirect with ce=1, then with ce=0 (load and hold), then back-to-back
    v_ce   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    v_chg  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    v_tgt  = '{32'hA, 32'h0, 32'h0, 32'hA, 32'h0, 32'h0, 32'h100, 32'h200, 32'h0};
    exp_pc = '{32'hA, 32'hE, 32'h12, 32'hA, 32'hA, 32'hA, 32'h100, 32'h200, 32'h204};
    exp_ce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      ce_in = v_ce[i]; change = v_chg[i]; target = v_tgt[i];
      tick();
      total++;
      if (pc_out !== exp_pc[i] || ce_out !== exp_ce[i]) begin
        bad++;
        $display("FAIL redirect step %0d: got pc=%h ce=%b expected pc=%h ce=%b",
                 i, pc_out, ce_out, exp_pc[i], exp_ce[i]);
      end
    end
    change = 1'b0;
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_pc [3];
    exp_pc = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    ce_in = 1'b1; change = 1'b1; target = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      tick();
      change = 1'b0;
      total++;
      if (pc_out !== exp_pc[i] || ce_out !== 1'b1) begin
        bad++;
        $display("FAIL wrap step %0d: got pc=%h ce=%b expected pc=%h ce=1",
                 i, pc_out, ce_out, exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ce_in = 1'b1; change = 1'b1; target = 32'h1C;
    tick();
    change = 1'b0;
    tick();
    total++;
    if (pc_out !== 32'h20) begin
      bad++;
      $display("FAIL midrst_setup: got pc=%h expected %h", pc_out, 32'h20);
    end
    rst = 1'b1; change = 1'b1; target = 32'h80;
    tick();
    total++;
    if (pc_out !== 32'h0 || ce_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_reset: got pc=%h ce=%b expected pc=0 ce=0", pc_out, ce_out);
    end
    rst = 1'b0; change = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (pc_out !== W'(4 * i) || ce_out !== 1'b1) begin
        bad++;
        $display("FAIL midrst_restart step %0d: got pc=%h ce=%b expected pc=%h ce=1",
                 i, pc_out, ce_out, W'(4 * i));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; ce_in = 1'b0; change = 1'b0; target = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
